// File: rtl/uart_rx_ctrl_pkg.sv
// Shared constants for the UART receive controller: config-FSM state codes,
// legal prescale values and reset defaults.
package uart_rx_ctrl_pkg;

    localparam logic [2:0] C_IDLE  = 3'd0;
    localparam logic [2:0] C_WAIT  = 3'd1;
    localparam logic [2:0] C_GATE  = 3'd2;
    localparam logic [2:0] C_APPLY = 3'd3;
    localparam logic [2:0] C_ACK   = 3'd4;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    localparam int unsigned PRESCALE_RST_DEF = 8;
    localparam bit          PAR_EN_RST_DEF   = 1'b1;
    localparam bit          PAR_TYP_RST_DEF  = 1'b0;

    function automatic logic prescale_legal(input logic [5:0] p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers; reports a single-cycle pulse
// whenever a push is dropped because the FIFO is full and not being popped.
module uart_rx_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic              full,
    output logic              ovf_pulse
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]       wptr_q, rptr_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_push, do_pop;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign ovf_pulse = push && full && !do_pop;

    assign rdata = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame qualification, receive FIFO and between-frame
// config switching. Define UART_RX_ERR_CNT_EN to build the error-frame counters.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned PRESCALE_RST = PRESCALE_RST_DEF,
    parameter bit          PAR_EN_RST   = PAR_EN_RST_DEF,
    parameter bit          PAR_TYP_RST  = PAR_TYP_RST_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              rx_busy,
    input  logic              rx_stop_strobe,
    input  logic [DATA_W-1:0] rx_p_data,
    input  logic              rx_par_err,
    input  logic              rx_stop_err,
    output logic              rx_en,
    output logic [5:0]        prescale,
    output logic              par_en,
    output logic              par_typ,
    input  logic              cfg_req,
    input  logic [5:0]        cfg_prescale,
    input  logic              cfg_par_en,
    input  logic              cfg_par_typ,
    output logic              cfg_ack,
    output logic              cfg_err,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_empty,
    output logic              rd_full,
    output logic              ovf,
    input  logic              ovf_clr,
    output logic [7:0]        par_err_cnt,
    output logic [7:0]        stop_err_cnt
);

    // ---------------- frame qualification ----------------
    logic eval_q;
    logic good_push;
    logic fifo_ovf;
    logic ovf_q;

    // One-cycle delay so the checker flags have settled when sampled.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) eval_q <= 1'b0;
        else      eval_q <= rx_stop_strobe;
    end

    assign good_push = eval_q && !rx_par_err && !rx_stop_err;

    uart_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (good_push),
        .wdata     (rx_p_data),
        .pop       (rd_en),
        .rdata     (rd_data),
        .empty     (rd_empty),
        .full      (rd_full),
        .ovf_pulse (fifo_ovf)
    );

    // A new overflow wins over a same-cycle clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)          ovf_q <= 1'b0;
        else if (fifo_ovf) ovf_q <= 1'b1;
        else if (ovf_clr)  ovf_q <= 1'b0;
    end

    assign ovf = ovf_q;

`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] par_cnt_q, stop_cnt_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_cnt_q  <= '0;
            stop_cnt_q <= '0;
        end else if (eval_q) begin
            if (rx_par_err && (par_cnt_q != 8'hFF))   par_cnt_q  <= par_cnt_q + 8'd1;
            if (rx_stop_err && (stop_cnt_q != 8'hFF)) stop_cnt_q <= stop_cnt_q + 8'd1;
        end
    end

    assign par_err_cnt  = par_cnt_q;
    assign stop_err_cnt = stop_cnt_q;
`else
    assign par_err_cnt  = '0;
    assign stop_err_cnt = '0;
`endif

    // ---------------- config FSM ----------------
    logic [2:0] state_q, state_d;
    logic       rx_en_q, rx_en_d;
    logic       cfg_ack_q, cfg_ack_d;
    logic       cfg_err_q, cfg_err_d;
    logic       load_shadow, apply;
    logic [5:0] sh_prescale_q, prescale_q;
    logic       sh_par_en_q, sh_par_typ_q, par_en_q, par_typ_q;

    always_comb begin
        state_d     = state_q;
        rx_en_d     = 1'b1;
        cfg_ack_d   = 1'b0;
        cfg_err_d   = 1'b0;
        load_shadow = 1'b0;
        apply       = 1'b0;
        unique case (state_q)
            C_IDLE: begin
                if (cfg_req) begin
                    if (!prescale_legal(cfg_prescale)) begin
                        state_d   = C_ACK;
                        cfg_ack_d = 1'b1;
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d     = C_WAIT;
                        load_shadow = 1'b1;
                    end
                end
            end
            C_WAIT: begin
                if (!rx_busy) begin
                    state_d = C_GATE;
                    rx_en_d = 1'b0;
                end
            end
            C_GATE: begin
                // A frame may have started on the gating boundary; let it finish.
                if (rx_busy) begin
                    state_d = C_WAIT;
                end else begin
                    state_d = C_APPLY;
                    rx_en_d = 1'b0;
                end
            end
            C_APPLY: begin
                apply     = 1'b1;
                state_d   = C_ACK;
                cfg_ack_d = 1'b1;
            end
            C_ACK: begin
                state_d = C_IDLE;
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= C_IDLE;
            rx_en_q       <= 1'b1;
            cfg_ack_q     <= 1'b0;
            cfg_err_q     <= 1'b0;
            sh_prescale_q <= 6'(PRESCALE_RST);
            sh_par_en_q   <= PAR_EN_RST;
            sh_par_typ_q  <= PAR_TYP_RST;
            prescale_q    <= 6'(PRESCALE_RST);
            par_en_q      <= PAR_EN_RST;
            par_typ_q     <= PAR_TYP_RST;
        end else begin
            state_q   <= state_d;
            rx_en_q   <= rx_en_d;
            cfg_ack_q <= cfg_ack_d;
            cfg_err_q <= cfg_err_d;
            if (load_shadow) begin
                sh_prescale_q <= cfg_prescale;
                sh_par_en_q   <= cfg_par_en;
                sh_par_typ_q  <= cfg_par_typ;
            end
            if (apply) begin
                prescale_q <= sh_prescale_q;
                par_en_q   <= sh_par_en_q;
                par_typ_q  <= sh_par_typ_q;
            end
        end
    end

    assign rx_en    = rx_en_q;
    assign cfg_ack  = cfg_ack_q;
    assign cfg_err  = cfg_err_q;
    assign prescale = prescale_q;
    assign par_en   = par_en_q;
    assign par_typ  = par_typ_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: queue scoreboard with an independent pop monitor,
// random frames, and directed config / overflow / reset scenarios.
module tb_uart_rx_ctrl;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 8;

    logic              CLK = 1'b0;
    logic              RST;
    logic              rx_busy, rx_stop_strobe, rx_par_err, rx_stop_err;
    logic [DATA_W-1:0] rx_p_data;
    logic              rx_en, par_en, par_typ;
    logic [5:0]        prescale;
    logic              cfg_req, cfg_par_en, cfg_par_typ, cfg_ack, cfg_err;
    logic [5:0]        cfg_prescale;
    logic              rd_en, rd_empty, rd_full, ovf, ovf_clr;
    logic [DATA_W-1:0] rd_data;
    logic [7:0]        par_err_cnt, stop_err_cnt;

    uart_rx_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .rx_busy        (rx_busy),
        .rx_stop_strobe (rx_stop_strobe),
        .rx_p_data      (rx_p_data),
        .rx_par_err     (rx_par_err),
        .rx_stop_err    (rx_stop_err),
        .rx_en          (rx_en),
        .prescale       (prescale),
        .par_en         (par_en),
        .par_typ        (par_typ),
        .cfg_req        (cfg_req),
        .cfg_prescale   (cfg_prescale),
        .cfg_par_en     (cfg_par_en),
        .cfg_par_typ    (cfg_par_typ),
        .cfg_ack        (cfg_ack),
        .cfg_err        (cfg_err),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_empty       (rd_empty),
        .rd_full        (rd_full),
        .ovf            (ovf),
        .ovf_clr        (ovf_clr),
        .par_err_cnt    (par_err_cnt),
        .stop_err_cnt   (stop_err_cnt)
    );

    always #5 CLK = ~CLK;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    bit         mon_en   = 1'b0;
    bit         exp_ovf  = 1'b0;
    int         par_n    = 0;
    int         stop_n   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef UART_RX_ERR_CNT_EN
        return (n > 255) ? 32'd255 : 32'(n);
`else
        return 32'd0;
`endif
    endfunction

    // Monitor: pops whenever the FIFO presents data and compares against the scoreboard.
    initial begin
        rd_en = 1'b0;
        forever begin
            @(negedge CLK);
            rd_en = 1'b0;
            if (mon_en && RST && !rd_empty && ($urandom_range(0, 3) != 0)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h expected none", rd_data);
                end else begin
                    check("fifo_data", 32'(rd_data), 32'(exp_q.pop_front()));
                end
                rd_en = 1'b1;
            end
        end
    end

    // One receive frame: busy, stop strobe, flags held through the eval cycle.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic se);
        rx_busy = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge CLK);
        rx_p_data      = d;
        rx_par_err     = pe;
        rx_stop_err    = se;
        rx_stop_strobe = 1'b1;
        @(negedge CLK);
        rx_stop_strobe = 1'b0;
        if (!pe && !se) begin
            if (mon_en || (exp_q.size() < DEPTH)) exp_q.push_back(d);
            else                                  exp_ovf = 1'b1;
        end
        if (pe) par_n++;
        if (se) stop_n++;
        @(negedge CLK);
        rx_busy     = 1'b0;
        rx_par_err  = 1'b0;
        rx_stop_err = 1'b0;
        rx_p_data   = 8'($urandom);
    endtask

    task automatic wait_drain(input string name);
        int cyc = 0;
        while ((exp_q.size() != 0 || !rd_empty) && cyc < 300) begin
            @(negedge CLK);
            cyc++;
        end
        check(name, 32'(cyc < 300), 32'd1);
        @(negedge CLK);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_en"}, 32'(rx_en), 32'd1);
        check({tag, "_prescale"}, 32'(prescale), 32'd8);
        check({tag, "_par_en"}, 32'(par_en), 32'd1);
        check({tag, "_par_typ"}, 32'(par_typ), 32'd0);
        check({tag, "_cfg_ack"}, 32'(cfg_ack), 32'd0);
        check({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
        check({tag, "_rd_empty"}, 32'(rd_empty), 32'd1);
        check({tag, "_rd_full"}, 32'(rd_full), 32'd0);
        check({tag, "_ovf"}, 32'(ovf), 32'd0);
        check({tag, "_par_cnt"}, 32'(par_err_cnt), 32'd0);
        check({tag, "_stop_cnt"}, 32'(stop_err_cnt), 32'd0);
    endtask

    // Issue a valid request and wait for ack; returns cycles to ack and rx_en-low cycles.
    task automatic cfg_cycle(input logic [5:0] p, input logic pe, input logic pt,
                             output int ack_cyc, output int low_cyc, output logic err);
        cfg_req      = 1'b1;
        cfg_prescale = p;
        cfg_par_en   = pe;
        cfg_par_typ  = pt;
        ack_cyc = -1;
        low_cyc = 0;
        err     = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLK);
            if (!rx_en) low_cyc++;
            if (cfg_ack) begin
                ack_cyc = c;
                err     = cfg_err;
                break;
            end
        end
        cfg_req = 1'b0;
    endtask

    initial begin
        int         ack_cyc, low_cyc, bad;
        logic       err;
        logic [7:0] d;

        RST = 1'b0;
        rx_busy = 0; rx_stop_strobe = 0; rx_par_err = 0; rx_stop_err = 0; rx_p_data = '0;
        cfg_req = 0; cfg_prescale = '0; cfg_par_en = 0; cfg_par_typ = 0; ovf_clr = 0;
        repeat (2) @(negedge CLK);
        check_reset_vals("reset");
        RST = 1'b1;
        @(negedge CLK);

        // Good frame 0xA5: visible two cycles after the strobe.
        rx_p_data = 8'hA5; rx_stop_strobe = 1'b1;
        @(negedge CLK);
        rx_stop_strobe = 1'b0;
        check("a5_empty_eval", 32'(rd_empty), 32'd1);
        @(negedge CLK);
        check("a5_empty_after", 32'(rd_empty), 32'd0);
        check("a5_data", 32'(rd_data), 32'hA5);
        rd_en = 1'b1;
        @(negedge CLK);
        rd_en = 1'b0;
        check("a5_popped_empty", 32'(rd_empty), 32'd1);

        // Valid config while idle.
        cfg_cycle(6'd16, 1'b0, 1'b1, ack_cyc, low_cyc, err);
        check("cfg16_ack_latency", 32'(ack_cyc), 32'd4);
        check("cfg16_rx_en_low", 32'(low_cyc), 32'd2);
        check("cfg16_err", 32'(err), 32'd0);
        check("cfg16_prescale", 32'(prescale), 32'd16);
        check("cfg16_par_en", 32'(par_en), 32'd0);
        check("cfg16_par_typ", 32'(par_typ), 32'd1);
        @(negedge CLK);
        check("cfg16_ack_one_cycle", 32'(cfg_ack), 32'd0);

        // Config while a frame is in flight: nothing changes until rx_busy falls.
        rx_busy = 1'b1;
        cfg_req = 1'b1; cfg_prescale = 6'd32; cfg_par_en = 1'b1; cfg_par_typ = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge CLK);
            if (prescale != 6'd16 || !rx_en || cfg_ack) bad++;
        end
        check("busy_hold", 32'(bad), 32'd0);
        rx_busy = 1'b0;
        cfg_cycle(6'd32, 1'b1, 1'b0, ack_cyc, low_cyc, err);
        check("busy_ack_seen", 32'(ack_cyc > 0), 32'd1);
        check("busy_prescale", 32'(prescale), 32'd32);
        @(negedge CLK);

        // Frame starting in the gate cycle bounces back to waiting.
        cfg_req = 1'b1; cfg_prescale = 6'd8; cfg_par_en = 1'b1; cfg_par_typ = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("gate_rx_en_low", 32'(rx_en), 32'd0);
        rx_busy = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge CLK);
            if (!rx_en || cfg_ack || prescale != 6'd32) bad++;
        end
        check("gate_bounce_hold", 32'(bad), 32'd0);
        rx_busy = 1'b0;
        cfg_cycle(6'd8, 1'b1, 1'b0, ack_cyc, low_cyc, err);
        check("gate_ack_seen", 32'(ack_cyc > 0), 32'd1);
        check("gate_prescale", 32'(prescale), 32'd8);
        @(negedge CLK);

        // Illegal prescale: rejected the cycle after sampling.
        cfg_req = 1'b1; cfg_prescale = 6'd12; cfg_par_en = 1'b0;
        @(negedge CLK);
        check("bad_ack", 32'(cfg_ack), 32'd1);
        check("bad_err", 32'(cfg_err), 32'd1);
        cfg_req = 1'b0;
        @(negedge CLK);
        check("bad_prescale", 32'(prescale), 32'd8);
        check("bad_par_en", 32'(par_en), 32'd1);

        // Random frames with scoreboard-checked output.
        mon_en = 1'b1;
        repeat (40) send_frame(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
        wait_drain("random_drain");
        check("random_par_cnt", 32'(par_err_cnt), exp_cnt(par_n));
        check("random_stop_cnt", 32'(stop_err_cnt), exp_cnt(stop_n));

        // Error frames: 3 parity, 1 both.
        repeat (3) send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1);
        repeat (2) @(negedge CLK);
        check("err_par_cnt", 32'(par_err_cnt), exp_cnt(par_n));
        check("err_stop_cnt", 32'(stop_err_cnt), exp_cnt(stop_n));
        check("err_fifo_empty", 32'(rd_empty), 32'd1);

        // Overflow with reads suspended.
        mon_en = 1'b0;
        @(negedge CLK);
        exp_ovf = 1'b0;
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
        @(negedge CLK);
        check("ovf_full", 32'(rd_full), 32'd1);
        check("ovf_flag", 32'(ovf), 32'(exp_ovf));
        mon_en = 1'b1;
        wait_drain("ovf_drain");
        check("ovf_sticky", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        @(negedge CLK);
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(ovf), 32'd0);

        // Saturation.
        repeat (260) send_frame(8'($urandom), 1'b1, 1'b0);
        repeat (2) @(negedge CLK);
        check("sat_par_cnt", 32'(par_err_cnt), exp_cnt(par_n));
        check("sat_stop_cnt", 32'(stop_err_cnt), exp_cnt(stop_n));

        // Async reset mid-frame with buffered data and a pending config.
        mon_en = 1'b0;
        @(negedge CLK);
        send_frame(8'h5A, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b1);
        rx_busy = 1'b1;
        cfg_req = 1'b1; cfg_prescale = 6'd32;
        @(negedge CLK);
        @(negedge CLK);
        #3 RST = 1'b0;
        #1 check_reset_vals("midreset");
        exp_q.delete();
        par_n = 0; stop_n = 0; exp_ovf = 1'b0;
        cfg_req = 1'b0; rx_busy = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge CLK);
            if (cfg_ack || prescale != 6'd8 || !rd_empty) bad++;
        end
        check("post_reset_quiet", 32'(bad), 32'd0);

        // Traffic resumes normally after reset.
        mon_en = 1'b1;
        d = 8'($urandom);
        send_frame(d, 1'b0, 1'b0);
        wait_drain("post_reset_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
